// File: rtl/xilinx_spdistram_ctrl.sv
// xilinx_spdistram_ctrl: valid/ready request front end for a single-port, async-read distributed RAM.
// Define SPDISTRAM_CTRL_INIT_EN to sweep INIT_VALUE into every location after each reset.
module xilinx_spdistram_ctrl #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_d,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_d,
  output logic                  busy,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_o,
  output logic                  dbg_state
);

  // Handshake: a request transfers on a rising wclk edge with req_valid & req_ready; a
  // response transfers with rsp_valid & rsp_ready. Neither side may assume the other
  // holds its payload stable while its own valid is low.

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_d_q;
  logic                  req_fire;
  logic                  rd_fire;

`ifdef SPDISTRAM_CTRL_INIT_EN
  localparam state_t              RESET_STATE = ST_INIT;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR   = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // One bit wider than the address so the terminal compare never sees a wrapped value.
  logic [ADDR_WIDTH:0] init_cnt_q;

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      init_cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      init_cnt_q <= init_cnt_q + CNT_ONE;
    end
  end
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef SPDISTRAM_CTRL_INIT_EN
    if ((state_q == ST_INIT) && (init_cnt_q == LAST_ADDR)) begin
      state_d = ST_RUN;
    end
`endif
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    ram_we    = 1'b0;
    ram_a     = req_a;
    ram_d     = req_d;
    case (state_q)
      ST_RUN: begin
        // One-entry response buffer: accept only when it is empty or draining this edge.
        req_ready = ~rsp_valid_q | rsp_ready;
        ram_we    = req_valid & (~rsp_valid_q | rsp_ready) & req_we;
      end
      default: begin
`ifdef SPDISTRAM_CTRL_INIT_EN
        busy   = 1'b1;
        ram_we = 1'b1;
        ram_a  = init_cnt_q[ADDR_WIDTH-1:0];
        ram_d  = INIT_VALUE;
`endif
      end
    endcase
  end

  assign req_fire = req_valid & req_ready;
  assign rd_fire  = req_fire & ~req_we;

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_d_q     <= '0;
    end else begin
      if (rd_fire) begin
        rsp_valid_q <= 1'b1;
        rsp_d_q     <= ram_o;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_d     = rsp_d_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_xilinx_spdistram_ctrl.sv
// Bench for xilinx_spdistram_ctrl: behavioural RAM, transaction-level memory/response model,
// directed steps followed by randomized traffic.
module tb_xilinx_spdistram_ctrl;

  localparam int             AW    = 6;
  localparam int             DW    = 8;
  localparam int             DEPTH = 64;
  localparam logic [DW-1:0]  INITV = 8'hA5;

  logic          wclk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_a;
  logic [DW-1:0] req_d;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_d;
  logic          busy;
  logic          ram_we;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_o;
  logic          dbg_state;

  int checks;
  int errors;

  // Reference model: memory image and pending response words.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_d;

  // Behavioural async-read RAM with a one-shot preload port for its power-up image.
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] img     [DEPTH];
  logic          preload;

  always #5 wclk = ~wclk;

  always @(posedge wclk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= img[i];
    end else if (ram_we) begin
      ram_mem[ram_a] <= ram_d;
    end
  end
  assign ram_o = ram_mem[ram_a];

  xilinx_spdistram_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .INIT_VALUE (INITV)
  ) dut (
    .wclk      (wclk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_a     (req_a),
    .req_d     (req_d),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_d     (rsp_d),
    .busy      (busy),
    .ram_we    (ram_we),
    .ram_a     (ram_a),
    .ram_d     (ram_d),
    .ram_o     (ram_o),
    .dbg_state (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request-side cycle; entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rr);
    logic exp_rdy;
    logic acc;
    req_valid = v;
    req_we    = we;
    req_a     = a;
    req_d     = d;
    rsp_ready = rr;
    #1;
    exp_rdy = (exp_q.size() == 0) || rr;
    acc     = v && exp_rdy;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("ram_we", 32'(ram_we), 32'(acc && we));
    @(posedge wclk);
    if ((exp_q.size() != 0) && rr) void'(exp_q.pop_front());
    if (acc) begin
      if (we) begin
        ref_mem[a] = d;
      end else begin
        exp_q.push_back(ref_mem[a]);
        last_d = ref_mem[a];
      end
    end
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
    chk("rsp_d", 32'(rsp_d), 32'(last_d));
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_d = '0;
`ifdef SPDISTRAM_CTRL_INIT_EN
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = INITV;
`endif
  endtask

`ifdef SPDISTRAM_CTRL_INIT_EN
  // Runs n sweep cycles with random request noise; if full, checks that RUN follows.
  task automatic init_phase(input int n, input logic full);
    for (int k = 0; k < n; k++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_a     = AW'($urandom_range(0, DEPTH - 1));
      req_d     = DW'($urandom_range(0, 255));
      rsp_ready = 1'b1;
      #1;
      chk("init_busy", 32'(busy), 32'd1);
      chk("init_req_ready", 32'(req_ready), 32'd0);
      chk("init_ram_we", 32'(ram_we), 32'd1);
      chk("init_ram_a", 32'(ram_a), 32'(k));
      chk("init_ram_d", 32'(ram_d), 32'(INITV));
      @(posedge wclk);
      #1;
    end
    if (full) begin
      req_valid = 1'b0;
      #1;
      chk("post_init_busy", 32'(busy), 32'd0);
      chk("post_init_req_ready", 32'(req_ready), 32'd1);
    end
  endtask
`endif

  initial begin
    logic [DW-1:0] w;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_a     = '0;
    req_d     = '0;
    rsp_ready = 1'b0;
    preload   = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      img[i]     = DW'($urandom_range(0, 255));
      ref_mem[i] = img[i];
    end
    model_reset();
    repeat (2) @(posedge wclk);
    #1;
    preload = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_d", 32'(rsp_d), 32'd0);
`ifdef SPDISTRAM_CTRL_INIT_EN
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
`else
    chk("rst_busy", 32'(busy), 32'd0);
`endif
    @(posedge wclk);
    #1;
    rst = 1'b0;

`ifdef SPDISTRAM_CTRL_INIT_EN
    init_phase(DEPTH, 1'b1);
`else
    rsp_ready = 1'b1;
    #1;
    chk("first_busy", 32'(busy), 32'd0);
    chk("first_req_ready", 32'(req_ready), 32'd1);
    @(posedge wclk);
    #1;
`endif

    // Contents after reset at the ends and middle of the array.
    cycle(1'b1, 1'b0, 6'd0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 6'd31, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 6'd63, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 6'd0, 8'h00, 1'b1);

    // Write followed immediately by a read of the same address.
    cycle(1'b1, 1'b1, 6'd12, 8'h3C, 1'b1);
    cycle(1'b1, 1'b0, 6'd12, 8'h00, 1'b1);
    chk("wr_rd_12", 32'(rsp_d), 32'h3C);
    cycle(1'b0, 1'b0, 6'd0, 8'h00, 1'b1);

    // Back-pressure: response pending, read of 5 must wait.
    cycle(1'b1, 1'b0, 6'd12, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 6'd5, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 6'd5, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 6'd5, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 6'd0, 8'h00, 1'b1);

    // Back-to-back reads of freshly written words.
    for (int i = 1; i <= 3; i++) begin
      w = DW'($urandom_range(0, 255));
      cycle(1'b1, 1'b1, AW'(i), w, 1'b1);
    end
    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, AW'(i), 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 6'd0, 8'h00, 1'b1);

    // Top address.
    cycle(1'b1, 1'b1, 6'd63, 8'h5A, 1'b1);
    cycle(1'b1, 1'b0, 6'd63, 8'h00, 1'b1);
    chk("rd_63", 32'(rsp_d), 32'h5A);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 255)),
            ($urandom_range(0, 3) != 0));
    end

    // Reset while a response is pending.
    cycle(1'b1, 1'b0, 6'd7, 8'h00, 1'b0);
    chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    model_reset();
    @(posedge wclk);
    #1;
    rst = 1'b0;
`ifdef SPDISTRAM_CTRL_INIT_EN
    init_phase(20, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_sweep_rst_busy", 32'(busy), 32'd1);
    chk("mid_sweep_rst_ram_a", 32'(ram_a), 32'd0);
    @(posedge wclk);
    #1;
    rst = 1'b0;
    init_phase(DEPTH, 1'b1);
`endif

    // Post-reset traffic, including the address written earlier.
    cycle(1'b1, 1'b0, 6'd12, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 6'd20, 8'h00, 1'b1);
    for (int n = 0; n < 100; n++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 255)),
            ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
